// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM state
// encoding and the digit-count helper used to reject undersized configurations.
package bcd_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    // Smallest digit count d with 10^d > 2^width - 1, i.e. no result can truncate.
    function automatic int min_digits(input int width);
        longint max_val;
        longint pow;
        int     d;
        max_val = (longint'(1) << width) - 1;
        pow     = 10;
        d       = 1;
        while (pow <= max_val) begin
            pow = pow * 10;
            d   = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// shift so that the doubled value carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter: one input bit per clock, registered
// result with leading-zero blanking flags and a one-cycle done pulse.
module bcd_seq_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [DIGITS-1:0]     blank
);

    localparam int                CNT_W     = $clog2(WIDTH + 1);
    localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS - 1){1'b1}}, 1'b0};

    if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
        $error("bcd_seq_converter: WIDTH must lie in 4..32");
    end

    if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
        $error("bcd_seq_converter: DIGITS too small to hold 2^WIDTH-1");
    end

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [WIDTH-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adjusted;
    logic [4*DIGITS-1:0] next_scratch;
    logic [DIGITS-1:0]   next_blank;
    logic                nonzero;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_add3 u_add3 (
            .din  (scratch[4*i +: 4]),
            .dout (adjusted[4*i +: 4])
        );
    end

    // Corrected scratch shifted left by one, pulling in the next binary bit.
    assign next_scratch = {adjusted[4*DIGITS-2:0], shreg[WIDTH-1]};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_blank = '0;
        nonzero    = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (next_scratch[4*i +: 4] != 4'd0) begin
                nonzero = 1'b1;
            end
            next_blank[i] = !nonzero;
        end
    end

    assign busy = (state == SHIFT);

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            count   <= '0;
            shreg   <= '0;
            scratch <= '0;
            bcd     <= '0;
            blank   <= BLANK_RST;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    shreg   <= binary;
                    scratch <= '0;
                    count   <= CNT_W'(WIDTH);
                    state   <= SHIFT;
                end
            end else begin
                scratch <= next_scratch;
                shreg   <= shreg << 1;
                count   <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    bcd   <= next_scratch;
                    blank <= next_blank;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: an 8-bit/3-digit and a 16-bit/5-digit
// instance, expected results queued at stimulus time and checked on each done.
module tb_bcd_seq_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle++;

    logic        rst8, start8, busy8, done8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;
    logic [2:0]  blank8;

    logic        rst16, start16, busy16, done16;
    logic [15:0] bin16;
    logic [19:0] bcd16;
    logic [4:0]  blank16;

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .binary(bin8),
        .busy(busy8), .done(done8), .bcd(bcd8), .blank(blank8)
    );

    bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .binary(bin16),
        .busy(busy16), .done(done16), .bcd(bcd16), .blank(blank16)
    );

    int tests = 0;
    int fails = 0;

    logic [14:0] q8[$];
    logic [24:0] q16[$];
    int          done_log[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model by decimal arithmetic: {bcd, blank}.
    function automatic logic [14:0] model8(input int v);
        logic [11:0] b;
        logic [2:0]  bl;
        b  = {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
        bl = {v < 100, v < 10, 1'b0};
        return {b, bl};
    endfunction

    function automatic logic [24:0] model16(input int v);
        logic [19:0] b;
        logic [4:0]  bl;
        int          p;
        b  = '0;
        bl = '0;
        p  = 1;
        for (int i = 0; i < 5; i++) begin
            b[4*i +: 4] = 4'(v / p % 10);
            if (i > 0) bl[i] = (v < p);
            p = p * 10;
        end
        return {b, bl};
    endfunction

    always @(negedge clk) begin
        if (done8) begin
            done_log.push_back(cycle);
            if (q8.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done8_unexpected: got done with bcd 0x%0h, expected no done (cycle %0d)", bcd8, cycle);
            end else begin
                logic [14:0] e;
                e = q8.pop_front();
                check("bcd8", 32'(bcd8), 32'(e[14:3]));
                check("blank8", 32'(blank8), 32'(e[2:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (done16) begin
            if (q16.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL done16_unexpected: got done with bcd 0x%0h, expected no done (cycle %0d)", bcd16, cycle);
            end else begin
                logic [24:0] e;
                e = q16.pop_front();
                check("bcd16", 32'(bcd16), 32'(e[24:5]));
                check("blank16", 32'(blank16), 32'(e[4:0]));
            end
        end
    end

    // Called at a negedge; returns at the negedge where done is visible.
    task automatic conv8(input int v, input logic [14:0] exp);
        int   lat;
        logic gap;
        bin8   = 8'(v);
        start8 = 1'b1;
        q8.push_back(exp);
        @(negedge clk);
        start8 = 1'b0;
        lat    = 0;
        gap    = 1'b0;
        while (!done8 && lat < 20) begin
            if (!busy8) gap = 1'b1;
            lat++;
            @(negedge clk);
        end
        check("latency8", 32'(lat), 32'd8);
        check("busy8_during", 32'(gap), 32'd0);
        check("busy8_at_done", 32'(busy8), 32'd0);
    endtask

    task automatic conv16(input int v, input logic [24:0] exp);
        int lat;
        bin16   = 16'(v);
        start16 = 1'b1;
        q16.push_back(exp);
        @(negedge clk);
        start16 = 1'b0;
        lat     = 0;
        while (!done16 && lat < 40) begin
            lat++;
            @(negedge clk);
        end
        check("latency16", 32'(lat), 32'd16);
    endtask

    initial begin
        rst8 = 1'b1; start8 = 1'b0; bin8 = '0;
        rst16 = 1'b1; start16 = 1'b0; bin16 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_bcd8", 32'(bcd8), 32'd0);
        check("rst_blank8", 32'(blank8), 32'b110);
        check("rst_blank16", 32'(blank16), 32'b11110);
        rst16 = 1'b0;

        // start together with reset must be ignored
        start8 = 1'b1;
        bin8   = 8'd55;
        @(negedge clk);
        check("start_with_rst_busy", 32'(busy8), 32'd0);
        rst8   = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        check("start_with_rst_busy_after", 32'(busy8), 32'd0);

        // directed, back-to-back (each start lands in the previous done cycle)
        conv8(255, {12'h255, 3'b000});
        conv8(7,   {12'h007, 3'b110});
        conv8(0,   {12'h000, 3'b110});
        conv8(42,  {12'h042, 3'b100});
        conv8(199, {12'h199, 3'b000});
        conv8(100, {12'h100, 3'b000});
        conv8(10,  {12'h010, 3'b100});
        conv8(9,   {12'h009, 3'b110});

        // idle with start low keeps the last result
        repeat (5) @(negedge clk);
        check("hold_bcd8", 32'(bcd8), 32'h009);
        check("hold_blank8", 32'(blank8), 32'b110);
        check("hold_busy8", 32'(busy8), 32'd0);

        // start held high: accepts at edges 0, 9, 18; binary disturbed while busy
        done_log.delete();
        repeat (3) q8.push_back({12'h042, 3'b100});
        for (int j = 0; j < 20; j++) begin
            bin8   = ((j >= 2 && j <= 6) || (j >= 11 && j <= 15)) ? 8'd99 : 8'd42;
            start8 = 1'b1;
            @(negedge clk);
        end
        start8 = 1'b0;
        repeat (10) @(negedge clk);
        check("held_done_count", 32'(done_log.size()), 32'd3);
        if (done_log.size() == 3) begin
            // a new start is sampled one edge after done, so spacing is WIDTH+1 edges
            check("held_gap1", 32'(done_log[1] - done_log[0]), 32'd9);
            check("held_gap2", 32'(done_log[2] - done_log[1]), 32'd9);
        end

        // reset at cycle 4 of a conversion of 199: discarded, no done
        bin8   = 8'd199;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("midrst_busy8", 32'(busy8), 32'd0);
        check("midrst_bcd8", 32'(bcd8), 32'd0);
        check("midrst_blank8", 32'(blank8), 32'b110);
        check("midrst_done8", 32'(done8), 32'd0);
        repeat (12) @(negedge clk);
        conv8(199, {12'h199, 3'b000});

        // full 8-bit sweep against the decimal model
        for (int v = 0; v < 256; v++) conv8(v, model8(v));

        // 16-bit instance
        conv16(65535, {20'h65535, 5'b00000});
        conv16(0,     {20'h00000, 5'b11110});
        conv16(10000, {20'h10000, 5'b00000});
        conv16(9999,  {20'h09999, 5'b10000});
        conv16(100,   {20'h00100, 5'b11000});
        for (int v = 0; v < 65536; v += 257) conv16(v, model16(v));
        conv16(65534, model16(65534));

        repeat (3) @(negedge clk);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q16_drained", 32'(q16.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
